// File: rtl/crc_pkg.sv
// Shared definitions for the byte-serial CRC generator and the frame checker:
// default polynomial, status codes, checker FSM states and the status classifier.
package crc_pkg;

  localparam int         CRC_WIDTH_DEF = 8;
  localparam logic [7:0] CRC_POLY_DEF  = 8'h07;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_CRC_ERR  = 2'd1,
    ST_SHORT    = 2'd2,
    ST_OVERFLOW = 2'd3
  } crc_status_e;

  typedef enum logic [1:0] {
    RECV   = 2'd0,
    DROP   = 2'd1,
    REPORT = 2'd2
  } crc_state_e;

  // Overflow wins over short, short wins over a bad residue.
  function automatic crc_status_e classify(input int len, input int max_len,
                                           input int min_len, input logic res_nz);
    if (len > max_len)      return ST_OVERFLOW;
    else if (len < min_len) return ST_SHORT;
    else if (res_nz)        return ST_CRC_ERR;
    else                    return ST_OK;
  endfunction

endpackage

// File: rtl/crc_byte_step.sv
// One-byte CRC update, MSB-first, non-reflected. Shared with the generator so
// both ends of the link compute the same value bit-for-bit.
module crc_byte_step #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'h07)
) (
  input  logic [WIDTH-1:0] crc_in,
  input  logic [7:0]       data_in,
  output logic [WIDTH-1:0] crc_out
);

  logic [WIDTH-1:0] c;
  logic [7:0]       d;
  logic             fb;

  always_comb begin
    c  = crc_in;
    d  = data_in;
    fb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fb = c[WIDTH-1] ^ d[7];
      c  = {c[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
      d  = {d[6:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/crc_frame_checker.sv
// Receive-side CRC frame checker: recomputes the CRC over payload plus trailing CRC
// bytes and reports OK / CRC_ERR / SHORT / OVERFLOW. CRC_CHECK_STATS_EN adds good/bad counters.
module crc_frame_checker
  import crc_pkg::*;
#(
  parameter int               WIDTH   = CRC_WIDTH_DEF,
  parameter logic [WIDTH-1:0] POLY    = WIDTH'(CRC_POLY_DEF),
  parameter int               MAX_LEN = 64,
  parameter int               LEN_W   = $clog2(MAX_LEN + 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             done,
  output logic [1:0]       status,
  output logic [LEN_W-1:0] frame_len,
  output logic [WIDTH-1:0] crc_residue
`ifdef CRC_CHECK_STATS_EN
  ,
  output logic [15:0]      good_cnt,
  output logic [15:0]      bad_cnt
`endif
);

  localparam int CRC_BYTES = WIDTH / 8;
  localparam int MIN_LEN   = CRC_BYTES + 1;

  // Handshake: a byte transfers on a rising edge where s_valid && s_ready;
  // s_data/s_last are don't-care otherwise. s_ready drops only in REPORT.
  crc_state_e       state_q, state_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  crc_status_e      status_q, status_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] crc_q, crc_d;
  logic [LEN_W-1:0] count_q, count_d;

  logic             accept;
  logic [LEN_W-1:0] count_inc;
  logic [WIDTH-1:0] crc_step;
  logic [LEN_W-1:0] fin_len;
  logic [WIDTH-1:0] fin_crc;
  crc_status_e      fin_status;

  crc_byte_step #(.WIDTH(WIDTH), .POLY(POLY)) u_step (
    .crc_in  (crc_q),
    .data_in (s_data),
    .crc_out (crc_step)
  );

  assign accept    = s_valid && ready_q;
  assign count_inc = count_q + LEN_W'(1);

  // In DROP the counter already sits at MAX_LEN+1 and the crc is frozen.
  assign fin_len    = (state_q == DROP) ? count_q : count_inc;
  assign fin_crc    = (state_q == DROP) ? crc_q : crc_step;
  assign fin_status = classify(int'(fin_len), MAX_LEN, MIN_LEN, |fin_crc);

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    status_d = status_q;
    len_d    = len_q;
    res_d    = res_q;
    crc_d    = crc_q;
    count_d  = count_q;
    case (state_q)
      RECV: begin
        if (accept) begin
          crc_d   = crc_step;
          count_d = count_inc;
          if (s_last) begin
            state_d  = REPORT;
            ready_d  = 1'b0;
            done_d   = 1'b1;
            status_d = fin_status;
            len_d    = fin_len;
            res_d    = fin_crc;
          end else if (count_q == LEN_W'(MAX_LEN)) begin
            state_d = DROP;
          end
        end
      end
      DROP: begin
        if (accept && s_last) begin
          state_d  = REPORT;
          ready_d  = 1'b0;
          done_d   = 1'b1;
          status_d = fin_status;
          len_d    = fin_len;
          res_d    = fin_crc;
        end
      end
      REPORT: begin
        crc_d   = '0;
        count_d = '0;
        ready_d = 1'b1;
        state_d = RECV;
      end
      default: begin
        state_d = RECV;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RECV;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      status_q <= ST_OK;
      len_q    <= '0;
      res_q    <= '0;
      crc_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      status_q <= status_d;
      len_q    <= len_d;
      res_q    <= res_d;
      crc_q    <= crc_d;
      count_q  <= count_d;
    end
  end

  assign s_ready     = ready_q;
  assign done        = done_q;
  assign status      = status_q;
  assign frame_len   = len_q;
  assign crc_residue = res_q;

`ifdef CRC_CHECK_STATS_EN
  logic [15:0] good_q, good_d;
  logic [15:0] bad_q, bad_d;

  // Counted in the REPORT cycle, from the registered status; both saturate.
  always_comb begin
    good_d = good_q;
    bad_d  = bad_q;
    if (done_q) begin
      if (status_q == ST_OK) begin
        if (good_q != 16'hFFFF) good_d = good_q + 16'd1;
      end else begin
        if (bad_q != 16'hFFFF) bad_d = bad_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      good_q <= good_d;
      bad_q  <= bad_d;
    end
  end

  assign good_cnt = good_q;
  assign bad_cnt  = bad_q;
`endif

endmodule
